r8_booth_encoder_seq: RTL
=========================

# r8_booth_encoder_seq

Sequential radix-8 modified-Booth encoder: accepts a signed multiplier operand and emits one 5-bit Booth selection word per cycle, least-significant digit first. Each word drives a row of 4-bit Booth selectors (x, 2x, 3x, 4x, negate) in the partial-product generator. The block sits between the operand register and the partial-product array / Dadda accumulation stage. Both sides use valid/ready handshakes.

## Interface
- N, 16, multiplier width in bits (two's complement, N >= 3)
- G, derived = ceil(N/3), number of radix-8 digits (N=16 -> G=6)
- IW, derived = max(1, $clog2(G)), digit index width
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  operand available
- in_ready  output  1  block accepts operand this cycle
- in_y  input  N  signed multiplier
- out_valid  output  1  out_sel/out_idx/out_last valid
- out_ready  input  1  downstream consumes current digit
- out_sel  output  5  [0]=|d|==1, [1]=|d|==2, [2]=|d|==3, [3]=|d|==4, [4]=negate
- out_idx  output  IW  digit index 0..G-1; partial-product weight is 8^idx
- out_last  output  1  high with digit G-1
- busy  output  1  FSM in RUN

## Operation
- Extension: in_y is sign-extended to 3G bits as Y. Y[-1] = 0.
- Digit i: d = -4*Y[3i+2] + 2*Y[3i+1] + Y[3i] + Y[3i-1]. The range is -4..+4.
- out_sel is one-hot in [3:0] for d != 0. For d == 0, out_sel = 5'b00000; negate is forced 0, including for the pattern 1111.
- out_sel[4] = 1 exactly when d < 0.
- Storage: a shift register of 3G+1 bits holds {Y, Y[-1]}. Its low 4 bits form the current digit window. Each consumed digit shifts the register right by 3, with arithmetic fill.
- FSM states: IDLE, RUN.
  - IDLE: in_ready=1, out_valid=0. On in_valid: load the register, set idx=0, go to RUN.
  - RUN: out_valid=1. out_sel is decoded combinationally from the registered window, so there are no glitch-free requirements on registered outputs.
  - RUN, on out_valid&out_ready with idx<G-1: shift, then idx++.
  - RUN, on out_valid&out_ready with idx==G-1 (out_last=1): with in_valid=1, load the new operand, set idx=0, and stay in RUN. Otherwise go to IDLE.
- in_ready = IDLE | (RUN & out_last & out_ready). This is a combinational path out_ready -> in_ready and is permitted.
- While RUN and not at the last digit, in_ready=0. in_y is ignored.
- Stall: with out_valid=1 and out_ready=0, out_sel, out_idx and out_last hold stable. The register does not shift.
- Reset: asserting rst_n low at any time, including mid-operand, goes immediately to IDLE and discards the partial operand.
- Reset values: shift register=0, idx=0, out_valid=0, out_sel=0, out_idx=0, out_last=0, busy=0. in_ready=1 once reset is released.
- Sum invariant: sum over i of d_i * 8^i equals the signed value of in_y.

## Timing
- Latency: operand accepted at edge t; digit 0 is valid in the cycle after t.
- Throughput with out_ready held high: G digits in G consecutive cycles.
- Back-to-back operands: digit 0 of the next operand follows digit G-1 of the previous one with no bubble.
- Isolated operand: G+1 cycles including the IDLE accept cycle.
- out_last is asserted only while out_idx==G-1 and out_valid=1.

## Test plan
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_sel=0, busy=0. After release -> in_ready=1.
- N=16, in_y=0x0003 -> idx0 sel=00100; idx1..5 sel=00000. out_last on idx5. Exactly 6 beats.
- in_y=0x0007 -> idx0 sel=10001 (-1), idx1 sel=00001 (+1), rest 0. in_y=0x0004 -> idx0 sel=11000 (-4), idx1 sel=00001.
- in_y=0xFFFF -> idx0 sel=10001; idx1..5 sel=00000 (the 1111 pattern encodes zero with no negate). in_y=0x8000 -> digits reconstruct -32768.
- Backpressure: toggle out_ready randomly -> outputs stable while stalled, no digits lost or duplicated. Back-to-back operands 0x0001 then 0x0002 with out_ready=1 -> 12 contiguous beats; in_ready pulses only in the cycle with out_last.
- Reset mid-operand at idx=3 -> out_valid drops immediately. A new operand is then accepted and starts at idx0. Random regression: every operand satisfies the sum invariant against a reference model.

Source files
------------

// File: rtl/r8_booth_encoder_seq.sv
// Sequential radix-8 Booth encoder: one 5-bit selector word per cycle,
// least-significant digit first, valid/ready on both sides.
module r8_booth_encoder_seq #(
   parameter  int N  = 16,
   localparam int G  = (N + 2) / 3,
   localparam int IW = (G > 1) ? $clog2(G) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [4:0]    out_sel,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   output logic          busy
);

   localparam int W = 3 * G + 1;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t        state;
   logic [W-1:0]  sreg;
   logic [IW-1:0] idx;
   logic [3*G-1:0] y_ext;
   logic          run;
   logic          last;
   logic [4:0]    sel;

   generate
      if (3 * G > N) begin : g_ext
         assign y_ext = {{(3 * G - N){in_y[N-1]}}, in_y};
      end else begin : g_noext
         assign y_ext = in_y;
      end
   endgenerate

   assign run       = (state == RUN);
   assign last      = run && (idx == IW'(G - 1));
   assign busy      = run;
   assign out_valid = run;
   assign out_last  = last;
   assign out_idx   = run ? idx : '0;
   assign out_sel   = run ? sel : '0;
   assign in_ready  = !run || (last && out_ready);

   // Window {Y[3i+2],Y[3i+1],Y[3i],Y[3i-1]}; 0000 and 1111 both encode zero
   always_comb begin
      sel = '0;
      unique case (sreg[3:0])
         4'b0001, 4'b0010: sel = 5'b00001;
         4'b0011, 4'b0100: sel = 5'b00010;
         4'b0101, 4'b0110: sel = 5'b00100;
         4'b0111:          sel = 5'b01000;
         4'b1000:          sel = 5'b11000;
         4'b1001, 4'b1010: sel = 5'b10100;
         4'b1011, 4'b1100: sel = 5'b10010;
         4'b1101, 4'b1110: sel = 5'b10001;
         default:          sel = 5'b00000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sreg  <= '0;
         idx   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  sreg  <= {y_ext, 1'b0};
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (out_ready) begin
                  if (!last) begin
                     sreg <= {{3{sreg[W-1]}}, sreg[W-1:3]};
                     idx  <= idx + IW'(1);
                  end else if (in_valid) begin
                     sreg <= {y_ext, 1'b0};
                     idx  <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
